iec_bus_hub: RTL
================

# iec_bus_hub

Parametrised IEC serial-bus hub for the drive subsystem. It merges the open-collector ATN/CLK/DATA contributions of the host and up to NDEV emulated drives into one wired-AND bus, and applies each drive's hardware ATN-acknowledge term. It delivers a synchronised, deglitched bus view with a configurable filter length to every drive, and generates the PHI2 rising/falling clock-enable pair with a configurable divider. It replaces the per-drive input synchroniser, deglitcher and PHI2 divider, so several drives can share one bus.

## Interface
Parameters:
- NDEV, 2: number of drive ports, 1..8.
- FILT_LEN, 2: cycles a synchronised line must hold a new level before the filtered view follows, 1..15.
- CLK_DIV, 32: clk32 cycles per PHI2 period; even, 4..64.
- IDLE_CYC, 256: cycles of all-released filtered bus before bus_idle asserts, 1..65535.

Ports (level 1 = released, 0 = pulled low, for every bus signal):
- clk32  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_atn_out  in  1  host ATN drive.
- host_clk_out  in  1  host CLK drive.
- host_data_out  in  1  host DATA drive.
- host_atn_in  out  1  raw wired-AND ATN, combinational.
- host_clk_in  out  1  raw wired-AND CLK, combinational.
- host_data_in  out  1  raw wired-AND DATA, combinational.
- dev_en  in  NDEV  drive present; a 0 bit forces that drive's contributions released.
- dev_clk_out  in  NDEV  per-drive CLK drive.
- dev_data_out  in  NDEV  per-drive DATA drive.
- dev_atna  in  NDEV  per-drive ATN-acknowledge bit.
- bus_atn  out  1  filtered ATN, common to all drives.
- bus_clk  out  1  filtered CLK.
- bus_data  out  1  filtered DATA.
- atn_fall  out  1  one-cycle pulse on each filtered ATN 1→0 transition.
- bus_idle  out  1  filtered bus fully released for at least IDLE_CYC cycles.
- p2_rise  out  1  PHI2 rising-edge enable pulse.
- p2_fall  out  1  PHI2 falling-edge enable pulse.

## Operation
- Wired-AND of the raw bus:
  - host_atn_in = host_atn_out.
  - host_clk_in = host_clk_out & AND over i of (dev_clk_eff[i]).
  - host_data_in = host_data_out & AND over i of (dev_data_eff[i]).
- Per-drive effective outputs:
  - dev_clk_eff[i] = ~dev_en[i] | dev_clk_out[i].
  - dev_data_eff[i] = ~dev_en[i] | (dev_data_out[i] & ~(dev_atna[i] ^ ~atn_s)).
  - atn_s is the 2-flop-synchronised host_atn_in.
  - Consequence: with ATN asserted (atn_s = 0) and atna = 0, the drive pulls DATA low; with atna = 1 it releases.
- While reset is high, every dev_*_eff is forced to 1.
- Synchroniser: each raw line passes through 2 flops (s1, s2), reset value 1.
- Filter, one per line, shared by all drives:
  - A 4-bit counter clears whenever s2 equals the filtered value.
  - Otherwise the counter increments; when it reaches FILT_LEN-1 the filtered value loads s2 and the counter clears.
  - A glitch shorter than FILT_LEN cycles never propagates.
- atn_fall: registered, set when the previous bus_atn is 1 and the next is 0.
- Idle counter, 16 bits:
  - Clears whenever any filtered line is 0.
  - Otherwise increments, saturating at IDLE_CYC.
  - bus_idle = (counter == IDLE_CYC).
- PHI2 divider: 6-bit counter counting 0..CLK_DIV-1, then wrapping.
  - p2_rise registered from (div == 0).
  - p2_fall registered from (div == CLK_DIV/2).
  - The two pulses are never high in the same cycle.

## Timing
- Reset values: s1/s2/filtered lines 1; filter and idle counters 0; bus_idle 0; atn_fall, p2_rise, p2_fall 0; div 0.
- host_*_in are combinational from the inputs; atn_s, which feeds the ATN-ack term, lags host_atn_out by 2 cycles.
- Filtered-line latency from a raw edge: 2 (sync) + FILT_LEN cycles, provided the level stays stable.
- atn_fall rises in the same cycle bus_atn goes 0 and lasts exactly 1 cycle.
- p2_rise first asserts in the cycle after reset deasserts, then every CLK_DIV cycles; p2_fall follows each p2_rise by CLK_DIV/2 cycles.
- Changing dev_en takes effect on host_*_in immediately (combinational).
- Reset asserted mid-filter or mid-count returns all state to reset values asynchronously. No pulse is emitted on reset entry or exit.
- Simultaneous low from several drives is a normal wired-AND case; the line releases only when the last drive releases.

## Test plan
- Reset release, CLK_DIV=32: p2_rise at cycles 1, 33, 65; p2_fall at cycles 17, 49; never coincident.
- host_atn_out 1→0 with NDEV=2, dev_en=2'b11, atna=0: host_data_in goes 0 two cycles later. Then set dev_atna=2'b11: host_data_in returns to 1 in the same cycle.
- FILT_LEN=2: a 1-cycle 0 glitch on dev_clk_out[0] leaves bus_clk at 1. A 4-cycle low drives bus_clk to 0 at edge +4 and pulses atn_fall never.
- dev_en=2'b01, dev_data_out[1]=0: host_data_in stays 1. Setting dev_en[1]=1 drops host_data_in to 0 in the same cycle.
- IDLE_CYC=8, all lines released: bus_idle rises 8 cycles after filters settle. A host_clk_out pulse low clears it, and it re-asserts 8 cycles after the filtered release.
- Assert reset while the bus is held low by drive 0: all dev_*_eff go 1, all filtered outputs go 1 and p2 pulses go 0 immediately, with no atn_fall pulse.

Source files
------------

// File: rtl/iec_bus_hub.sv
// IEC serial-bus hub: wired-AND merge of host and drive contributions, shared
// synchroniser/deglitch filter, bus-idle detector and PHI2 enable generator.
module iec_bus_hub #(
  parameter int NDEV     = 2,
  parameter int FILT_LEN = 2,
  parameter int CLK_DIV  = 32,
  parameter int IDLE_CYC = 256
) (
  input  logic            clk32,
  input  logic            reset,
  input  logic            host_atn_out,
  input  logic            host_clk_out,
  input  logic            host_data_out,
  output logic            host_atn_in,
  output logic            host_clk_in,
  output logic            host_data_in,
  input  logic [NDEV-1:0] dev_en,
  input  logic [NDEV-1:0] dev_clk_out,
  input  logic [NDEV-1:0] dev_data_out,
  input  logic [NDEV-1:0] dev_atna,
  output logic            bus_atn,
  output logic            bus_clk,
  output logic            bus_data,
  output logic            atn_fall,
  output logic            bus_idle,
  output logic            p2_rise,
  output logic            p2_fall
);

  localparam logic [3:0]  FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYC);
  localparam logic [5:0]  DIV_MAX  = 6'(CLK_DIV - 1);
  localparam logic [5:0]  DIV_HALF = 6'(CLK_DIV / 2);

  // Line vectors are ordered {atn, clk, data}.
  logic [2:0]      raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      filt;
  logic [2:0]      filt_next;
  logic [2:0][3:0] cnt;
  logic [2:0][3:0] cnt_next;
  logic [15:0]     idle_cnt;
  logic [5:0]      div;
  logic            atn_s;

  logic [NDEV-1:0] dev_clk_eff;
  logic [NDEV-1:0] dev_data_eff;

  assign atn_s = s2[2];

  // A drive acks ATN by pulling DATA whenever its atna bit equals the synchronised ATN level.
  always_comb begin
    dev_clk_eff  = ~dev_en | dev_clk_out | {NDEV{reset}};
    dev_data_eff = ~dev_en | (dev_data_out & ~(dev_atna ^ {NDEV{~atn_s}})) | {NDEV{reset}};
  end

  assign host_atn_in  = host_atn_out;
  assign host_clk_in  = host_clk_out & (&dev_clk_eff);
  assign host_data_in = host_data_out & (&dev_data_eff);
  assign raw          = {host_atn_in, host_clk_in, host_data_in};

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_comb begin
    filt_next = filt;
    cnt_next  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (s2[i] != filt[i]) begin
        if (cnt[i] == FILT_MAX) begin
          filt_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      filt     <= '1;
      cnt      <= '0;
      atn_fall <= 1'b0;
    end else begin
      filt     <= filt_next;
      cnt      <= cnt_next;
      atn_fall <= filt[2] & ~filt_next[2];
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (filt != 3'b111) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      div     <= '0;
      p2_rise <= 1'b0;
      p2_fall <= 1'b0;
    end else begin
      div     <= (div == DIV_MAX) ? '0 : div + 6'd1;
      p2_rise <= (div == '0);
      p2_fall <= (div == DIV_HALF);
    end
  end

  assign bus_atn  = filt[2];
  assign bus_clk  = filt[1];
  assign bus_data = filt[0];
  assign bus_idle = (idle_cnt == IDLE_MAX);

endmodule
